// File: rtl/scaler_h_ctrl_if.sv
// Host configuration and scaler-side signals of the horizontal scaler controller.
// SCALER_H_CTRL_READBACK_EN adds the shadow-bank/pending-step readback signals.
interface scaler_h_ctrl_if #(
    parameter int ADR_WIDTH  = 10,
    parameter int DATA_WIDTH = 40
);
    logic                  vs_i;
    logic                  step_wr;
    logic [15:0]           step_i;
    logic                  coe_wr;
    logic [ADR_WIDTH-1:0]  coe_wadr;
    logic [DATA_WIDTH-1:0] coe_wdat;
    logic                  cfg_commit;
    logic                  cfg_busy;
    logic                  cfg_err;
    logic                  swapped_o;
    logic                  coe_adr_en;
    logic [ADR_WIDTH-1:0]  coe_adr;
    logic [DATA_WIDTH-1:0] coe_o;
    logic [15:0]           scale_step_o;
    logic                  bank_o;
`ifdef SCALER_H_CTRL_READBACK_EN
    logic                  rd_en;
    logic [ADR_WIDTH-1:0]  rd_adr;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [15:0]           rd_step;

    modport master (
        output vs_i, step_wr, step_i, coe_wr, coe_wadr, coe_wdat, cfg_commit,
               coe_adr_en, coe_adr, rd_en, rd_adr,
        input  cfg_busy, cfg_err, swapped_o, coe_o, scale_step_o, bank_o,
               rd_dat, rd_step
    );
    modport slave (
        input  vs_i, step_wr, step_i, coe_wr, coe_wadr, coe_wdat, cfg_commit,
               coe_adr_en, coe_adr, rd_en, rd_adr,
        output cfg_busy, cfg_err, swapped_o, coe_o, scale_step_o, bank_o,
               rd_dat, rd_step
    );
`else
    modport master (
        output vs_i, step_wr, step_i, coe_wr, coe_wadr, coe_wdat, cfg_commit,
               coe_adr_en, coe_adr,
        input  cfg_busy, cfg_err, swapped_o, coe_o, scale_step_o, bank_o
    );
    modport slave (
        input  vs_i, step_wr, step_i, coe_wr, coe_wadr, coe_wdat, cfg_commit,
               coe_adr_en, coe_adr,
        output cfg_busy, cfg_err, swapped_o, coe_o, scale_step_o, bank_o
    );
`endif
endinterface

// File: rtl/scaler_h_ctrl.sv
// Horizontal cubic scaler config controller: double-banked coefficient RAM and live
// step, swapped atomically at frame start. SCALER_H_CTRL_READBACK_EN adds readback.
//
// state | meaning
// IDLE  | host may write shadow bank / pending step, waits for cfg_commit
// PEND  | commit requested, host writes rejected, waits for vs rising edge
// SWAP  | one cycle: active bank toggles and pending step goes live
module scaler_h_ctrl #(
    parameter int SCALE_STEP = 4096,
    parameter int COE_WIDTH  = 10,
    parameter int COE_COUNT  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    scaler_h_ctrl_if.slave bus
);
    localparam int ADR_WIDTH  = $clog2(SCALE_STEP / COE_COUNT);
    localparam int DATA_WIDTH = COE_WIDTH * COE_COUNT;
    localparam int DEPTH      = 2 ** (ADR_WIDTH + 1);
    localparam logic [15:0] STEP_RST = 16'(SCALE_STEP);

    typedef enum logic [1:0] {IDLE, PEND, SWAP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  vs_d;
    logic                  vs_rise;
    logic                  coe_we;
    logic                  step_we;
    logic                  err_nxt;
    logic                  bank;
    logic [15:0]           pend_step;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign vs_rise = bus.vs_i & ~vs_d;

    always_comb begin
        state_nxt     = state;
        coe_we        = 1'b0;
        step_we       = 1'b0;
        err_nxt       = 1'b0;
        bus.cfg_busy  = 1'b0;
        bus.swapped_o = 1'b0;
        case (state)
            IDLE: begin
                coe_we  = bus.coe_wr;
                step_we = bus.step_wr && (bus.step_i != 16'd0);
                err_nxt = bus.step_wr && (bus.step_i == 16'd0);
                // a vs edge coinciding with the commit is not used; apply waits a frame
                if (bus.cfg_commit)
                    state_nxt = PEND;
            end
            PEND: begin
                bus.cfg_busy = 1'b1;
                err_nxt      = bus.coe_wr | bus.step_wr;
                if (vs_rise)
                    state_nxt = SWAP;
            end
            SWAP: begin
                bus.cfg_busy  = 1'b1;
                bus.swapped_o = 1'b1;
                err_nxt       = bus.coe_wr | bus.step_wr;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            vs_d             <= 1'b1;
            bus.cfg_err      <= 1'b0;
            bank             <= 1'b0;
            bus.scale_step_o <= STEP_RST;
            pend_step        <= STEP_RST;
            bus.coe_o        <= '0;
        end else begin
            state       <= state_nxt;
            vs_d        <= bus.vs_i;
            bus.cfg_err <= err_nxt;
            if (step_we)
                pend_step <= bus.step_i;
            if (state == SWAP) begin
                bank             <= ~bank;
                bus.scale_step_o <= pend_step;
            end
            // bank is still the old one during SWAP, so that read sees the old table
            if (bus.coe_adr_en)
                bus.coe_o <= mem[{bank, bus.coe_adr}];
        end
    end

    always_ff @(posedge clk) begin
        if (coe_we)
            mem[{~bank, bus.coe_wadr}] <= bus.coe_wdat;
    end

    assign bus.bank_o = bank;

`ifdef SCALER_H_CTRL_READBACK_EN
    always_ff @(posedge clk) begin
        if (bus.rd_en)
            bus.rd_dat <= mem[{~bank, bus.rd_adr}];
    end

    assign bus.rd_step = pend_step;
`endif
endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Directed + randomized bench for scaler_h_ctrl against a bank/step reference model.
module tb_scaler_h_ctrl;
    localparam int AW = 10;
    localparam int DW = 40;
    localparam int N  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scaler_h_ctrl_if #(.ADR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    scaler_h_ctrl #(.SCALE_STEP(4096), .COE_WIDTH(10), .COE_COUNT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: two tables, which one is live, live/pending step, commit outstanding
    logic [DW-1:0] ref_mem [2][N];
    logic          ref_bank;
    logic [15:0]   ref_step;
    logic [15:0]   ref_pend;
    logic          ref_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_bank = 1'b0;
        ref_step = 16'd4096;
        ref_pend = 16'd4096;
        ref_busy = 1'b0;
    endtask

    task automatic wr_coe(input int a, input logic [DW-1:0] d);
        logic exp_err;
        bus.coe_wr   = 1'b1;
        bus.coe_wadr = a[AW-1:0];
        bus.coe_wdat = d;
        tick();
        bus.coe_wr = 1'b0;
        exp_err = ref_busy;
        if (!ref_busy)
            ref_mem[~ref_bank][a] = d;
        chk("cfg_err_coe_wr", bus.cfg_err, exp_err);
    endtask

    task automatic wr_step(input logic [15:0] s);
        logic exp_err;
        bus.step_wr = 1'b1;
        bus.step_i  = s;
        tick();
        bus.step_wr = 1'b0;
        exp_err = ref_busy || (s == 16'd0);
        if (!exp_err)
            ref_pend = s;
        chk("cfg_err_step_wr", bus.cfg_err, exp_err);
    endtask

    task automatic commit();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        ref_busy = 1'b1;
        chk("busy_after_commit", bus.cfg_busy, 1'b1);
    endtask

    // one vs rising edge; optionally issue a scaler read in the cycle after the rise sample
    task automatic frame(input int rd_a);
        logic exp_sw;
        bus.vs_i = 1'b0;
        tick();
        bus.vs_i = 1'b1;
        tick();
        exp_sw = ref_busy;
        chk("swapped_pulse", bus.swapped_o, exp_sw);
        chk("busy_in_swap", bus.cfg_busy, ref_busy);
        if (rd_a >= 0) begin
            bus.coe_adr_en = 1'b1;
            bus.coe_adr    = rd_a[AW-1:0];
        end
        tick();
        bus.coe_adr_en = 1'b0;
        if (rd_a >= 0)
            chk("coe_o_swap_cycle_read", bus.coe_o, ref_mem[ref_bank][rd_a]);
        if (exp_sw) begin
            ref_bank = ~ref_bank;
            ref_step = ref_pend;
            ref_busy = 1'b0;
        end
        chk("swapped_single", bus.swapped_o, 1'b0);
        chk("bank_o", bus.bank_o, ref_bank);
        chk("scale_step_o", bus.scale_step_o, ref_step);
        chk("busy_after_frame", bus.cfg_busy, ref_busy);
        bus.vs_i = 1'b0;
    endtask

    task automatic rd(input int a);
        logic [DW-1:0] exp;
        exp = ref_mem[ref_bank][a];
        bus.coe_adr_en = 1'b1;
        bus.coe_adr    = a[AW-1:0];
        tick();
        bus.coe_adr_en = 1'b0;
        bus.coe_adr    = AW'($urandom_range(0, N - 1));
        chk("coe_o_read", bus.coe_o, exp);
        tick();
        chk("coe_o_hold", bus.coe_o, exp);
    endtask

`ifdef SCALER_H_CTRL_READBACK_EN
    task automatic rb(input int a);
        bus.rd_en  = 1'b1;
        bus.rd_adr = a[AW-1:0];
        tick();
        bus.rd_en = 1'b0;
        chk("rd_dat", bus.rd_dat, ref_mem[~ref_bank][a]);
        chk("rd_step", bus.rd_step, ref_pend);
    endtask
`endif

    initial begin
        logic [15:0] s1;
        logic [15:0] s2;
        logic [DW-1:0] d;

        bus.vs_i = 1'b0;      bus.step_wr = 1'b0;    bus.step_i = '0;
        bus.coe_wr = 1'b0;    bus.coe_wadr = '0;     bus.coe_wdat = '0;
        bus.cfg_commit = 1'b0; bus.coe_adr_en = 1'b0; bus.coe_adr = '0;
`ifdef SCALER_H_CTRL_READBACK_EN
        bus.rd_en = 1'b0;     bus.rd_adr = '0;
`endif

        // reset
        rst_n = 1'b0;
        tick();
        tick();
        model_reset();
        chk("rst_step", bus.scale_step_o, 16'd4096);
        chk("rst_bank", bus.bank_o, 1'b0);
        chk("rst_busy", bus.cfg_busy, 1'b0);
        chk("rst_swapped", bus.swapped_o, 1'b0);
        chk("rst_err", bus.cfg_err, 1'b0);
        chk("rst_coe_o", bus.coe_o, '0);
        rst_n = 1'b1;
        tick();

        // load shadow with data=adr, step 2048, commit, swap ten cycles later
        for (int a = 0; a < N; a++)
            wr_coe(a, DW'(a));
        wr_step(16'd2048);
        commit();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_pending", bus.cfg_busy, 1'b1);
            chk("no_swap_pending", bus.swapped_o, 1'b0);
        end
        frame(-1);
        chk("step_2048", bus.scale_step_o, 16'd2048);
        rd(5);
        for (int i = 0; i < 3; i++)
            rd($urandom_range(0, N - 1));

        // random table, then writes rejected while pending
        for (int a = 0; a < N; a++)
            wr_coe(a, DW'({$urandom(), $urandom()}));
`ifdef SCALER_H_CTRL_READBACK_EN
        for (int i = 0; i < 4; i++)
            rb($urandom_range(0, N - 1));
`endif
        s1 = 16'($urandom_range(1, 65535));
        wr_step(s1);
        commit();
        wr_coe(7, DW'({$urandom(), $urandom()}));
        wr_step(16'd1000);
        tick();
        chk("err_cleared", bus.cfg_err, 1'b0);
        frame(9);
        chk("step_precommit", bus.scale_step_o, s1);
        rd(7);

        // commit in the same cycle as vs rise, with a step write accepted alongside
        s2 = 16'($urandom_range(1, 65535));
        bus.cfg_commit = 1'b1;
        bus.step_wr    = 1'b1;
        bus.step_i     = s2;
        bus.vs_i       = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        bus.step_wr    = 1'b0;
        ref_pend = s2;
        ref_busy = 1'b1;
        chk("same_cycle_busy", bus.cfg_busy, 1'b1);
        chk("same_cycle_err", bus.cfg_err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("same_cycle_no_swap", bus.swapped_o, 1'b0);
        end
        frame(-1);
        chk("step_s2", bus.scale_step_o, s2);
        rd($urandom_range(0, N - 1));

        // zero step rejected; coe_wr alongside commit accepted
        wr_step(16'd0);
        d = DW'({$urandom(), $urandom()});
        bus.cfg_commit = 1'b1;
        bus.coe_wr     = 1'b1;
        bus.coe_wadr   = AW'(3);
        bus.coe_wdat   = d;
        tick();
        bus.cfg_commit = 1'b0;
        bus.coe_wr     = 1'b0;
        ref_mem[~ref_bank][3] = d;
        ref_busy = 1'b1;
        chk("commit_wr_err", bus.cfg_err, 1'b0);
        chk("commit_wr_busy", bus.cfg_busy, 1'b1);
        frame(-1);
        chk("step_unchanged", bus.scale_step_o, s2);
        rd(3);

        // reset while pending drops the commit
        commit();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        model_reset();
        chk("rstp_bank", bus.bank_o, 1'b0);
        chk("rstp_step", bus.scale_step_o, 16'd4096);
        chk("rstp_busy", bus.cfg_busy, 1'b0);
        chk("rstp_coe_o", bus.coe_o, '0);
        rst_n = 1'b1;
        tick();
        frame(-1);
        rd($urandom_range(0, N - 1));
`ifdef SCALER_H_CTRL_READBACK_EN
        rb($urandom_range(0, N - 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/scaler_h_ctrl.md
Name: scaler_h_ctrl

Overview:
Configuration controller for the horizontal cubic scaler. It owns a double-banked coefficient RAM and the live scale step. The host writes a new coefficient table and step into the shadow bank at any time. Both are applied atomically at the next frame start, so the scaler never sees a half-updated table mid-frame. The scaler reads coefficients from the active bank through its coe_adr/coe_i interface.

Parameters:
SCALE_STEP, 4096, fixed-point 1.000; reset value of the live step
COE_WIDTH, 10, width of one coefficient
COE_COUNT, 4, coefficients per table entry (taps)
ADR_WIDTH (localparam), $clog2(SCALE_STEP/COE_COUNT) = 10, table address width

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  synchronous reset, active-low
vs_i  in  1  vertical sync aligned with scaler input; frame start = rising edge
step_wr  in  1  write strobe for pending step
step_i  in  16  pending scale step value
coe_wr  in  1  shadow-bank write strobe
coe_wadr  in  ADR_WIDTH  shadow-bank write address
coe_wdat  in  COE_WIDTH*COE_COUNT  shadow-bank write data
cfg_commit  in  1  request apply of shadow config at next frame start
cfg_busy  out  1  commit pending; host writes rejected
cfg_err  out  1  one-cycle pulse when a write is rejected
swapped_o  out  1  one-cycle pulse in the cycle the bank and step switch
coe_adr_en  in  1  scaler read enable
coe_adr  in  ADR_WIDTH  scaler read address
coe_o  out  COE_WIDTH*COE_COUNT  active-bank coefficient data, to scaler coe_i
scale_step_o  out  16  live step, to scaler scale_step
bank_o  out  1  index of the active bank

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Storage: two banks of 2^ADR_WIDTH words, each COE_WIDTH*COE_COUNT bits, inferred RAM. Bank = address MSB; the active bank is bank_o, the shadow bank is ~bank_o.
- Read path:
  - When coe_adr_en=1, coe_o <= active_bank[coe_adr], 1-cycle latency.
  - coe_o holds its value when coe_adr_en=0.
  - Reads use bank_o as registered at the read cycle. A read in the swap cycle returns old-bank data; the next read returns new-bank data.
- Reset values: cfg_busy=0, cfg_err=0, swapped_o=0, bank_o=0, scale_step_o=SCALE_STEP, coe_o=0, pending step register=SCALE_STEP, FSM=IDLE. RAM contents are not reset.
- vs edge detect: vs_d <= vs_i; vs_rise = vs_i & ~vs_d. vs_d resets to 1, so no false rise after reset while vs_i is high.
- FSM: IDLE, PEND, SWAP.
  - IDLE:
    - coe_wr writes the shadow bank.
    - step_wr with step_i!=0 loads the pending step.
    - step_wr with step_i==0 is ignored and pulses cfg_err.
    - cfg_commit -> PEND. cfg_busy=1 from the next cycle.
  - PEND:
    - coe_wr, step_wr and cfg_commit are ignored; each coe_wr or step_wr pulses cfg_err (cfg_commit does not).
    - On vs_rise -> SWAP.
  - SWAP (exactly 1 cycle):
    - bank_o toggles and scale_step_o <= pending step.
    - swapped_o=1 for this cycle; cfg_busy stays 1.
    - Next state is IDLE; cfg_busy=0 from the next cycle.
- Simultaneous events:
  - cfg_commit and vs_rise in the same IDLE cycle: enter PEND only; apply waits for the next vs_rise.
  - coe_wr with cfg_commit in IDLE: the write is accepted, then commit proceeds.
  - step_wr with cfg_commit in IDLE: the write is accepted, then commit proceeds.
- Shadow-bank content: after a swap, the new shadow bank holds the previous active table, not a copy of the new one. The host rewrites the full table before every commit.
- Reset mid-PEND or mid-SWAP: return to reset values. The pending commit is dropped and bank 0 is active.
- cfg_err: registered, 1-cycle pulse per rejected strobe.
- Widths: the step is an unsigned 16-bit pass-through with no saturation.

Optional Feature:
SCALER_H_CTRL_READBACK_EN
- Defined: adds ports rd_en (in, 1), rd_adr (in, ADR_WIDTH), rd_dat (out, COE_WIDTH*COE_COUNT) and rd_step (out, 16).
  - rd_dat <= shadow_bank[rd_adr] when rd_en=1, 1-cycle latency, via a second read port.
  - rd_step = pending step register, combinational.
  - Readback is allowed in every state.
- Undefined: these ports and the second read port do not exist. The RAM is simple dual-port: one write port, one read port.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> scale_step_o=4096, bank_o=0, cfg_busy=0, swapped_o=0, coe_o=0.
- Load and swap:
  - Stimulus: write shadow adr 0..1023 with data=adr; step_i=2048; cfg_commit; vs_i 0->1 ten cycles later.
  - Required: cfg_busy=1 until the swap; swapped_o pulses exactly once, one cycle after the vs_rise sample cycle.
  - Required: then bank_o=1, scale_step_o=2048, and a read of coe_adr=5 returns 5 on coe_o one cycle later.
- Rejection in PEND: after commit, coe_wr to adr 7 and step_wr 1000 -> two cfg_err pulses; after the swap, adr 7 holds its pre-commit value and scale_step_o equals the pre-commit pending step.
- Same-cycle commit and vs_rise: cfg_commit in the cycle vs_i rises -> no swap this frame; swap occurs at the next vs_rise.
- Zero step: step_wr with 0 in IDLE -> cfg_err pulse; a subsequent commit and swap keeps scale_step_o unchanged.
- Reset while PEND: commit, then rst_n=0 before vs_rise -> bank_o=0, scale_step_o=4096; no swapped_o at the following vs_rise. With SCALER_H_CTRL_READBACK_EN defined, rd_dat matches shadow writes with 1-cycle latency.
